// File: rtl/rom_ram_pkg.sv
// Shared encodings and parameter limits for the ROM-to-RAM copy engine.
package rom_ram_pkg;

  // Engine states; IDLE must stay at zero so the state output resets to 0.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Job mode: COPY moves ROM words, FILL writes a constant word.
  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_t;

  // Supported ROM read latency range, in clock edges.
  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/rom_ram_tag_pipe.sv
// Tag pipeline matching the ROM read latency. Each issued read pushes
// {valid, destination address}; the tag leaves the last stage on the same
// edge the ROM data for that read is sampled.
module rom_ram_tag_pipe #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              empty
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];

  // Shift tags one stage per edge; flush kills every in-flight valid bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid & ~flush;
      addr_q[0]  <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1] & ~flush;
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];
  assign empty     = ~|valid_q;

endmodule

// File: rtl/rom_ram_copier.sv
// Block copy / constant fill engine from a fixed-latency ROM read port into a
// RAM write port, one word per cycle.
// Handshake: start is a one-cycle request honoured only in IDLE; busy is high
// from the cycle after acceptance until the job ends; done is sticky and is
// cleared by the next accepted start; abort cancels a running job at the next
// edge and leaves done low.
module rom_ram_copier
  import rom_ram_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 19,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output state_t            fsm_state
);

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("rom_ram_copier: RD_LATENCY out of range");
  end

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [ADDR_W-1:0] next_src_q;
  logic [ADDR_W-1:0] next_dst_q;
  logic [ADDR_W-1:0] remaining_q;

  logic              accept;
  logic              issue;
  logic              flush;
  logic              finish;
  logic [ADDR_W-1:0] tag_addr;
  logic              tag_valid;
  logic [ADDR_W-1:0] tag_out_addr;
  logic              pipe_empty;

  // Next-state and control strobes. The accepting edge already issues
  // index 0, so rom_addr is valid in the first busy cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    flush   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept  = 1'b1;
            issue   = 1'b1;
            state_d = (length == ONE) ? DRAIN : ISSUE;
          end else begin
            finish = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else begin
          issue = 1'b1;
          if (remaining_q == ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (pipe_empty) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Job parameters, issue-side address counters and the sticky done flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= MODE_COPY;
      fill_q      <= '0;
      rom_addr    <= '0;
      next_src_q  <= '0;
      next_dst_q  <= '0;
      remaining_q <= '0;
      done        <= 1'b0;
    end else begin
      if (accept) begin
        mode_q      <= mode_t'(mode);
        fill_q      <= fill_value;
        rom_addr    <= src_base;
        next_src_q  <= src_base + ONE;
        next_dst_q  <= dst_base + ONE;
        remaining_q <= length - ONE;
        done        <= 1'b0;
      end else if (issue) begin
        rom_addr    <= next_src_q;
        next_src_q  <= next_src_q + ONE;
        next_dst_q  <= next_dst_q + ONE;
        remaining_q <= remaining_q - ONE;
      end
      if (finish) done <= 1'b1;
    end
  end

  assign tag_addr = accept ? dst_base : next_dst_q;

  rom_ram_tag_pipe #(
    .DEPTH  (RD_LATENCY),
    .ADDR_W (ADDR_W)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (issue),
    .in_addr   (tag_addr),
    .out_valid (tag_valid),
    .out_addr  (tag_out_addr),
    .empty     (pipe_empty)
  );

  // Write-side registers: load when a tag matures, hold address/data otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_wren   <= 1'b0;
      ram_wraddr <= '0;
      ram_data   <= '0;
    end else begin
      ram_wren <= tag_valid & ~flush;
      if (tag_valid && !flush) begin
        ram_wraddr <= tag_out_addr;
        ram_data   <= (mode_q == MODE_FILL) ? fill_q : rom_data;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_rom_ram_copier.sv
// Bench for rom_ram_copier: three instances (RD_LATENCY 1, 2, 3) share the
// job inputs; each has its own ROM model of matching latency.
module tb_rom_ram_copier;
  import rom_ram_pkg::*;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int NI = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset;
  logic          start, abort, mode;
  logic [AW-1:0] src_base, dst_base, length;
  logic [DW-1:0] fill_value;

  logic          busy_v     [NI];
  logic          done_v     [NI];
  logic [AW-1:0] rom_addr_v [NI];
  logic [AW-1:0] ram_wraddr_v [NI];
  logic [DW-1:0] ram_data_v [NI];
  logic          ram_wren_v [NI];
  state_t        st_v       [NI];

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return (a[7:0] ^ 8'h5A) + a[15:8] + {5'b0, a[18:16]};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [DW-1:0] rom_pipe [3];
    logic [DW-1:0] rom_q;
    always @(posedge clk) begin
      rom_pipe[0] <= rom_fn(rom_addr_v[g]);
      rom_pipe[1] <= rom_pipe[0];
      rom_pipe[2] <= rom_pipe[1];
    end
    if (g == 0) begin : g_comb
      assign rom_q = rom_fn(rom_addr_v[g]);
    end else begin : g_reg
      assign rom_q = rom_pipe[g-1];
    end
    rom_ram_copier #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(g + 1)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .mode       (mode),
      .src_base   (src_base),
      .dst_base   (dst_base),
      .length     (length),
      .fill_value (fill_value),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .rom_addr   (rom_addr_v[g]),
      .rom_data   (rom_q),
      .ram_wraddr (ram_wraddr_v[g]),
      .ram_data   (ram_data_v[g]),
      .ram_wren   (ram_wren_v[g]),
      .fsm_state  (st_v[g])
    );
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (RD_LATENCY=%0d) at cycle %0d: got %0h, expected %0h",
               name, g + 1, cyc, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      check({tag, " rom_addr"}, g, 32'(rom_addr_v[g]), 32'd0);
      check({tag, " ram_wraddr"}, g, 32'(ram_wraddr_v[g]), 32'd0);
      check({tag, " ram_data"}, g, 32'(ram_data_v[g]), 32'd0);
      check({tag, " ram_wren"}, g, 32'(ram_wren_v[g]), 32'd0);
      check({tag, " busy"}, g, 32'(busy_v[g]), 32'd0);
      check({tag, " done"}, g, 32'(done_v[g]), 32'd0);
      check({tag, " state"}, g, 32'(st_v[g]), 32'(IDLE));
    end
  endtask

  // ---------------- job vectors ----------------
  typedef struct {
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    logic [DW-1:0] fill;
    int            abort_at;    // abort edge, counted in edges after the start edge (0 = none)
    int            restart_at;  // cycle of an extra start pulse while busy (0 = none)
    logic [AW-1:0] exp_last;    // last written address for completed jobs
  } job_t;

  job_t jobs [7];
  job_t post_job;

  // Drives one job, then checks every cycle: busy/done/rom_addr timing and
  // each write's address, data and cycle against the job's expected sequence.
  task automatic run_job(input job_t j);
    int            wr_cnt [NI];
    logic [AW-1:0] last_a [NI];
    int            end_c, exp_cnt, lat, issue_end, ci;
    logic [AW-1:0] ea, er;
    logic [DW-1:0] ed;
    @(negedge clk);
    mode = j.mode; src_base = j.src; dst_base = j.dst; length = j.len;
    fill_value = j.fill; abort = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < NI; g++) begin
      wr_cnt[g] = 0;
      last_a[g] = '0;
    end
    issue_end = (j.abort_at != 0) ? j.abort_at - 1 : int'(j.len) - 1;
    for (int c = 0; c < int'(j.len) + 8; c++) begin
      for (int g = 0; g < NI; g++) begin
        lat = g + 1;
        if (j.len == '0)          end_c = 0;
        else if (j.abort_at != 0) end_c = j.abort_at;
        else                      end_c = int'(j.len) + lat;
        check("busy", g, 32'(busy_v[g]), 32'((j.len != '0) && (c < end_c)));
        check("done", g, 32'(done_v[g]), 32'((j.abort_at == 0) && (c >= end_c)));
        if (j.len != '0) begin
          ci = (c < issue_end) ? c : issue_end;
          er = j.src + AW'(ci);
          check("rom_addr", g, 32'(rom_addr_v[g]), 32'(er));
        end
        if (ram_wren_v[g]) begin
          ea = j.dst + AW'(wr_cnt[g]);
          ed = j.mode ? j.fill : rom_fn(j.src + AW'(wr_cnt[g]));
          check("wr_addr", g, 32'(ram_wraddr_v[g]), 32'(ea));
          check("wr_data", g, 32'(ram_data_v[g]), 32'(ed));
          check("wr_cycle", g, 32'(c), 32'(lat + wr_cnt[g]));
          last_a[g] = ram_wraddr_v[g];
          wr_cnt[g]++;
        end
      end
      abort = (j.abort_at != 0) && (c == j.abort_at - 1);
      if (j.restart_at != 0 && c == j.restart_at) begin
        start = 1'b1; mode = ~j.mode; src_base = j.src + 19'd7;
        dst_base = j.dst + 19'd9; length = 19'd3; fill_value = ~j.fill;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    for (int g = 0; g < NI; g++) begin
      exp_cnt = (j.abort_at != 0) ? j.abort_at - (g + 1) : int'(j.len);
      check("wr_count", g, 32'(wr_cnt[g]), 32'(exp_cnt));
      if (j.abort_at == 0 && j.len != '0)
        check("last_addr", g, 32'(last_a[g]), 32'(j.exp_last));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    src_base = '0; dst_base = '0; length = '0; fill_value = '0;

    //          mode  src        dst        len        fill   abort rst  last
    jobs[0] = '{1'b0, 19'd0,     19'd0,     19'd19200, 8'h00, 0,    0,   19'd19199};
    jobs[1] = '{1'b0, 19'd100,   19'd5000,  19'd16,    8'h00, 0,    0,   19'd5015};
    jobs[2] = '{1'b1, 19'h00300, 19'h7FFFE, 19'd4,     8'hA5, 0,    0,   19'h00001};
    jobs[3] = '{1'b0, 19'd7,     19'd9,     19'd0,     8'h00, 0,    0,   19'd0};
    jobs[4] = '{1'b0, 19'h7FFFA, 19'h00200, 19'd32,    8'h00, 10,   0,   19'd0};
    jobs[5] = '{1'b0, 19'h01234, 19'h00040, 19'd12,    8'h00, 0,    0,   19'h0004B};
    jobs[6] = '{1'b1, 19'd50,    19'h00100, 19'd20,    8'h3C, 0,    4,   19'h00113};
    post_job = '{1'b0, 19'd10,   19'd20,    19'd8,     8'h00, 0,    0,   19'd27};

    repeat (3) @(negedge clk);
    check_zero("in_reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("after_reset");

    for (int i = 0; i < 7; i++) run_job(jobs[i]);

    // Asynchronous reset in the middle of a running job.
    @(negedge clk);
    mode = 1'b0; src_base = 19'd300; dst_base = 19'd600; length = 19'd40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    for (int g = 0; g < NI; g++) check("pre_reset wren", g, 32'(ram_wren_v[g]), 32'd1);
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    check_zero("held_reset");
    reset = 1'b1;
    run_job(post_job);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
